// File: rtl/dummy_adc.sv
// dummy_adc: stand-in ADC for the slot model. Samples the 6-bit slot bus once
// per tick, groups three samples, and writes a framed 4-byte message into the
// inbound FIFO using a two-cycle strobe per byte (data/write first, then
// fifo_clk high).
//
// Optional build macro: DUMMY_ADC_TESTPATTERN_EN
//   When defined, slot_data is ignored and samples come from a 6-bit ramp that
//   advances on every tick with direction=1.
module dummy_adc #(
    parameter int CLK_DIV    = 256,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  fifo_clk,
    output logic [7:0]            fifo_data,
    output logic                  fifo_write,
    input  logic [ADDR_WIDTH-1:0] fifo_addr_in,
    input  logic [ADDR_WIDTH-1:0] fifo_addr_out,
    input  logic [5:0]            slot_data,
    input  logic                  direction,
    input  logic                  channels,
    output logic [7:0]            overflow_count
);

    localparam int TW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        CHECK   = 2'd1,
        WRITE   = 2'd2
    } state_t;

    state_t state, state_n;

    logic [TW-1:0]         tick_cnt;
    logic                  tick;
    logic [1:0]            sample_cnt;
    logic [2:0][5:0]       s;
    logic [5:0]            sample;
    logic [4:0]            seq;
    logic [1:0]            byte_idx;
    logic                  phase;      // 0 = phase A (data/write), 1 = phase B (strobe high)
    logic [ADDR_WIDTH-1:0] used;
    logic [ADDR_WIDTH-1:0] free;
    logic                  room;
    logic                  group_done;
    logic                  last_beat;

    assign tick       = (tick_cnt == TW'(CLK_DIV - 1));
    assign group_done = (state == CAPTURE) && tick && direction && (sample_cnt == 2'd2);
    assign last_beat  = (state == WRITE) && phase && (byte_idx == 2'd3);

    // Occupancy is the modular pointer distance; one entry is always reserved,
    // so free = depth - 1 - used, which is simply the bitwise complement.
    assign used = fifo_addr_in - fifo_addr_out;
    assign free = {ADDR_WIDTH{1'b1}} - used;
    assign room = (free >= ADDR_WIDTH'(4));

`ifdef DUMMY_ADC_TESTPATTERN_EN
    logic [5:0] ramp;

    // Deterministic sample source: ramp advances on every accepted tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ramp <= '0;
        else if (tick && direction)
            ramp <= ramp + 6'd1;
    end

    assign sample = ramp;
`else
    assign sample = slot_data;
`endif

    // Free-running sample-rate divider; keeps counting in every state
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    // Sample capture: fill s[0..2]; a tick with direction low discards the partial group
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt <= '0;
            s          <= '0;
        end else if (state == CAPTURE && tick) begin
            if (direction) begin
                s[sample_cnt] <= sample;
                sample_cnt    <= (sample_cnt == 2'd2) ? 2'd0 : sample_cnt + 2'd1;
            end else begin
                sample_cnt <= '0;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= CAPTURE;
        else
            state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            CAPTURE: if (group_done) state_n = CHECK;
            CHECK:   state_n = room ? WRITE : CAPTURE;
            WRITE:   if (phase && byte_idx == 2'd3) state_n = CAPTURE;
            default: state_n = CAPTURE;
        endcase
    end

    // Burst sequencing: byte index and A/B phase within each byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx <= '0;
            phase    <= 1'b0;
        end else if (state == CHECK) begin
            byte_idx <= '0;
            phase    <= 1'b0;
        end else if (state == WRITE) begin
            phase <= ~phase;
            if (phase)
                byte_idx <= byte_idx + 2'd1;
        end
    end

    // FIFO-side outputs, registered so they change only on clk edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_data  <= '0;
            fifo_write <= 1'b0;
            fifo_clk   <= 1'b0;
        end else begin
            case (state)
                CHECK: begin
                    // Header is built here so channels is sampled in CHECK
                    if (room) begin
                        fifo_data  <= {2'b10, channels, seq};
                        fifo_write <= 1'b1;
                        fifo_clk   <= 1'b0;
                    end
                end
                WRITE: begin
                    if (!phase) begin
                        fifo_clk <= 1'b1;
                    end else if (byte_idx == 2'd3) begin
                        fifo_write <= 1'b0;
                        fifo_clk   <= 1'b0;
                    end else begin
                        // Payload byte n+1 carries sample n
                        fifo_clk  <= 1'b0;
                        fifo_data <= {2'b00, s[byte_idx]};
                    end
                end
                default: begin
                    fifo_write <= 1'b0;
                    fifo_clk   <= 1'b0;
                end
            endcase
        end
    end

    // Message sequence number advances only on a completed burst
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            seq <= '0;
        else if (last_beat)
            seq <= seq + 5'd1;
    end

    // Dropped-group counter, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow_count <= '0;
        else if (state == CHECK && !room && overflow_count != 8'hFF)
            overflow_count <= overflow_count + 8'd1;
    end

endmodule

// File: tb/tb_dummy_adc.sv
// tb_dummy_adc: directed, table-driven bench for dummy_adc with CLK_DIV=16.
module tb_dummy_adc;

    localparam int CLK_DIV = 16;
    localparam int AW      = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_clk;
    logic [7:0]    fifo_data;
    logic          fifo_write;
    logic [AW-1:0] fifo_addr_in = '0;
    logic [AW-1:0] fifo_addr_out = '0;
    logic [5:0]    slot_data = '0;
    logic          direction = 1'b0;
    logic          channels = 1'b0;
    logic [7:0]    overflow_count;

    dummy_adc #(.CLK_DIV(CLK_DIV), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_clk       (fifo_clk),
        .fifo_data      (fifo_data),
        .fifo_write     (fifo_write),
        .fifo_addr_in   (fifo_addr_in),
        .fifo_addr_out  (fifo_addr_out),
        .slot_data      (slot_data),
        .direction      (direction),
        .channels       (channels),
        .overflow_count (overflow_count)
    );

    always #5 clk = ~clk;

    // FIFO-side monitor: record every rising edge of fifo_clk
    logic       prev_fclk = 1'b0;
    logic [7:0] cap_q[$];
    logic       wr_q[$];
    time        t_q[$];

    always @(negedge clk) begin
        if (fifo_clk && !prev_fclk) begin
            cap_q.push_back(fifo_data);
            wr_q.push_back(fifo_write);
            t_q.push_back($time);
        end
        prev_fclk <= fifo_clk;
    end

    typedef struct {
        logic [5:0]    s0, s1, s2;
        logic          ch;
        logic [AW-1:0] ain, aout;
        bit            wr;
        logic [7:0]    hdr;
        logic [7:0]    ovf;
    } vec_t;

    vec_t       vt[12];
    int         n_chk = 0;
    int         n_pass = 0;
    int         ph = 0;
    logic [5:0] ramp = '0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        ph = (ph + 1) % CLK_DIV;
        #1;
    endtask

    // Drive one sample and advance to the clock edge on which the DUT ticks
    task automatic do_tick(input logic [5:0] v, input logic d, output logic [5:0] e);
        slot_data = v;
        direction = d;
        do step(); while (ph != 0);
`ifdef DUMMY_ADC_TESTPATTERN_EN
        e = ramp;
        if (d) ramp = ramp + 6'd1;
`else
        e = v;
`endif
    endtask

    task automatic chk_burst(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] exp_b[4];
        exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3;
        chk({nm, " nbytes"}, cap_q.size(), 4);
        if (cap_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("%s byte%0d", nm, i), cap_q[i], exp_b[i]);
                chk($sformatf("%s write%0d", nm, i), wr_q[i], 1);
                if (i > 0) chk($sformatf("%s spacing%0d", nm, i), int'(t_q[i] - t_q[i-1]), 20);
            end
        end
        cap_q.delete(); wr_q.delete(); t_q.delete();
    endtask

    initial begin
        logic [5:0] e0, e1, e2;

        vt[0]  = '{6'h15, 6'h2A, 6'h3F, 1'b1, 11'h000, 11'h000, 1'b1, 8'hA0, 8'd0};
        vt[1]  = '{6'h01, 6'h02, 6'h03, 1'b1, 11'h000, 11'h000, 1'b1, 8'hA1, 8'd0};
        vt[2]  = '{6'h3F, 6'h00, 6'h3F, 1'b0, 11'h000, 11'h000, 1'b1, 8'h82, 8'd0};
        vt[3]  = '{6'h10, 6'h20, 6'h30, 1'b1, 11'h000, 11'h000, 1'b1, 8'hA3, 8'd0};
        vt[4]  = '{6'h0A, 6'h0B, 6'h0C, 1'b1, 11'h000, 11'h000, 1'b1, 8'hA4, 8'd0};
        vt[5]  = '{6'h01, 6'h01, 6'h01, 1'b1, 11'h7FE, 11'h001, 1'b0, 8'h00, 8'd1}; // free=2
        vt[6]  = '{6'h11, 6'h22, 6'h33, 1'b1, 11'h7FE, 11'h400, 1'b1, 8'hA5, 8'd1};
        vt[7]  = '{6'h05, 6'h06, 6'h07, 1'b1, 11'h003, 11'h000, 1'b1, 8'hA6, 8'd1};
        vt[8]  = '{6'h2E, 6'h1D, 6'h0C, 1'b1, 11'h7FB, 11'h000, 1'b1, 8'hA7, 8'd1}; // free=4
        vt[9]  = '{6'h01, 6'h02, 6'h03, 1'b1, 11'h7FC, 11'h000, 1'b0, 8'h00, 8'd2}; // free=3
        vt[10] = '{6'h01, 6'h02, 6'h03, 1'b1, 11'h002, 11'h005, 1'b0, 8'h00, 8'd3}; // wrap, free=2
        vt[11] = '{6'h3A, 6'h15, 6'h2A, 1'b0, 11'h000, 11'h005, 1'b1, 8'h88, 8'd3}; // wrap, free=4

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst fifo_clk", fifo_clk, 0);
        chk("rst fifo_write", fifo_write, 0);
        chk("rst fifo_data", fifo_data, 0);
        chk("rst overflow", overflow_count, 0);
        @(negedge clk);
        reset = 1'b0;
        ph = 0;

        // Table: one group of three samples per vector
        for (int i = 0; i < 12; i++) begin
            fifo_addr_in  = vt[i].ain;
            fifo_addr_out = vt[i].aout;
            channels      = vt[i].ch;
            do_tick(vt[i].s0, 1'b1, e0);
            do_tick(vt[i].s1, 1'b1, e1);
            do_tick(vt[i].s2, 1'b1, e2);
            repeat (10) step();
            if (vt[i].wr)
                chk_burst($sformatf("vec%0d", i), vt[i].hdr, {2'b00, e0}, {2'b00, e1}, {2'b00, e2});
            else begin
                chk($sformatf("vec%0d nowrite", i), cap_q.size(), 0);
                cap_q.delete(); wr_q.delete(); t_q.delete();
            end
            chk($sformatf("vec%0d overflow", i), overflow_count, vt[i].ovf);
        end

        // Direction drops after two samples: broken group is never written
        fifo_addr_in = '0; fifo_addr_out = '0; channels = 1'b1;
        do_tick(6'h01, 1'b1, e0);
        do_tick(6'h02, 1'b1, e0);
        do_tick(6'h00, 1'b0, e0);
        repeat (10) step();
        chk("dirdrop nowrite", cap_q.size(), 0);
        do_tick(6'h2B, 1'b1, e0);
        do_tick(6'h2C, 1'b1, e1);
        do_tick(6'h2D, 1'b1, e2);
        repeat (10) step();
        chk_burst("dirdrop next", 8'hA9, {2'b00, e0}, {2'b00, e1}, {2'b00, e2});

        // Reset asserted during byte-2 phase B
        do_tick(6'h05, 1'b1, e0);
        do_tick(6'h06, 1'b1, e1);
        do_tick(6'h07, 1'b1, e2);
        repeat (6) step();
        chk("midrst pre fifo_clk", fifo_clk, 1);
        chk("midrst pre fifo_data", fifo_data, {2'b00, e1});
        reset = 1'b1;
        #1;
        chk("midrst fifo_clk", fifo_clk, 0);
        chk("midrst fifo_write", fifo_write, 0);
        chk("midrst fifo_data", fifo_data, 0);
        chk("midrst overflow", overflow_count, 0);
        @(negedge clk);
        reset = 1'b0;
        ph = 0;
        ramp = '0;
        cap_q.delete(); wr_q.delete(); t_q.delete();
        do_tick(6'h31, 1'b1, e0);
        do_tick(6'h32, 1'b1, e1);
        do_tick(6'h33, 1'b1, e2);
        repeat (10) step();
        chk_burst("postrst", 8'hA0, {2'b00, e0}, {2'b00, e1}, {2'b00, e2});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
